// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART TX core: one source holds the grant for a whole message.
// Optional stall timeout is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_soft_clr,
  input  logic [3:0] i_req,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  input  logic [7:0] i_data2,
  input  logic [7:0] i_data3,
  input  logic [3:0] i_last,
  output logic [3:0] o_ack,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_done,
  output logic [3:0] o_grant,
  output logic       o_busy,
  output logic       o_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_rr_ptr, r_gidx;
  logic [3:0] r_grant, r_ack;
  logic [7:0] r_tx_data;
  logic       r_tx_start, r_last_q;
  logic [3:0] w_rot;
  logic [1:0] w_off, w_win;
  logic       w_any, w_req_g, w_accept, w_to;
  logic [7:0] w_data_g;

  // Rotate requests so bit 0 is the source at rr_ptr; lowest set bit wins.
  assign w_rot = 4'({i_req, i_req} >> r_rr_ptr);
  assign w_any = |i_req;
  assign w_win = r_rr_ptr + w_off;

  always_comb begin
    w_off = 2'd3;
    if      (w_rot[0]) w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  always_comb begin
    case (r_gidx)
      2'd0:    w_data_g = i_data0;
      2'd1:    w_data_g = i_data1;
      2'd2:    w_data_g = i_data2;
      default: w_data_g = i_data3;
    endcase
  end

  assign w_req_g  = i_req[r_gidx];
  assign w_accept = (r_state == S_SEND) && w_req_g && !i_soft_clr;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [16:0] r_stall;
  logic        r_timeout;

  // Fires on the edge that ends the TIMEOUT_CYC-th consecutive stalled SEND cycle.
  assign w_to = (r_state == S_SEND) && !w_req_g && !i_soft_clr &&
                (r_stall >= 17'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        r_stall <= '0;
    else if (w_next == S_SEND && r_state != S_SEND)  r_stall <= '0;
    else if (w_accept)                               r_stall <= '0;
    else if (r_state == S_SEND && !w_req_g && r_stall != '1) r_stall <= r_stall + 17'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_timeout <= 1'b0;
    else      r_timeout <= w_to;
  end
  assign o_timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC != 0);
  assign w_to         = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_soft_clr) w_next = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (w_any) w_next = S_SEND;
        S_SEND:  if (w_req_g) w_next = S_WAIT;
                 else if (w_to) w_next = S_IDLE;
        S_WAIT:  if (i_tx_done) w_next = r_last_q ? S_IDLE : S_SEND;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= 2'd0;
      r_gidx     <= 2'd0;
      r_grant    <= 4'd0;
      r_ack      <= 4'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_last_q   <= 1'b0;
    end else begin
      r_tx_start <= w_accept;
      r_ack      <= w_accept ? r_grant : 4'd0;
      if (w_accept) begin
        r_tx_data <= w_data_g;
        r_last_q  <= i_last[r_gidx];
      end
      if (i_soft_clr) begin
        r_grant <= 4'd0;
      end else if (r_state == S_IDLE && w_any) begin
        r_grant <= 4'(1) << w_win;
        r_gidx  <= w_win;
      end else if (w_to || (r_state == S_WAIT && i_tx_done && r_last_q)) begin
        r_grant  <= 4'd0;
        r_rr_ptr <= r_gidx + 2'd1;
      end
    end
  end

  assign o_grant    = r_grant;
  assign o_ack      = r_ack;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized + directed bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int TO = 20;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b0, soft_clr = 1'b0, tx_done = 1'b0;
  logic [3:0] req = 4'd0, lst = 4'd0;
  logic [7:0] dat [4];
  logic [3:0] o_ack, o_grant;
  logic       o_tx_start, o_busy, o_timeout;
  logic [7:0] o_tx_data;

  uart_tx_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .i_soft_clr(soft_clr), .i_req(req),
    .i_data0(dat[0]), .i_data1(dat[1]), .i_data2(dat[2]), .i_data3(dat[3]),
    .i_last(lst), .o_ack(o_ack), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(tx_done), .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference: who owns the TX, whether a byte is on the wire, and the last registered outputs.
  typedef struct {
    int owner; bit infl; bit lastq; int rr; int stall;
    bit start; logic [3:0] ack; logic [7:0] data; bit to;
  } mdl_t;
  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t n;
    n.owner = -1; n.infl = 0; n.lastq = 0; n.rr = 0; n.stall = 0;
    n.start = 0; n.ack = 4'd0; n.data = 8'h00; n.to = 0;
    return n;
  endfunction

  function automatic mdl_t mnext(mdl_t c);
    mdl_t n = c;
    n.start = 0; n.ack = 4'd0; n.to = 0;
    if (soft_clr) begin
      n.owner = -1; n.infl = 0;
    end else if (c.owner < 0) begin
      for (int k = 0; k < 4; k++)
        if (n.owner < 0 && req[(c.rr + k) % 4]) n.owner = (c.rr + k) % 4;
      n.stall = 0;
    end else if (!c.infl) begin
      if (req[c.owner]) begin
        n.start = 1; n.ack = 4'(1 << c.owner); n.data = dat[c.owner];
        n.lastq = lst[c.owner]; n.infl = 1; n.stall = 0;
      end else begin
        n.stall = c.stall + 1;
        if (TO_EN && n.stall >= TO) begin
          n.to = 1; n.rr = (c.owner + 1) % 4; n.owner = -1;
        end
      end
    end else if (tx_done) begin
      n.infl = 0; n.stall = 0;
      if (c.lastq) begin n.rr = (c.owner + 1) % 4; n.owner = -1; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m <= mreset();
    else      m <= mnext(m);

  logic [18:0] cmp_e, cmp_a;
  always @(negedge clk) begin
    cmp_e = {(m.owner < 0) ? 4'd0 : 4'(1 << m.owner), m.owner >= 0, m.start, m.ack, m.to, m.data};
    cmp_a = {o_grant, o_busy, o_tx_start, o_ack, o_timeout, o_tx_data};
    total++;
    if (cmp_a !== cmp_e) begin
      bad++;
      $display("FAIL outputs t=%0t got=%h want=%h", $time, cmp_a, cmp_e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Source and TX-core stimulus state
  logic [7:0] sbuf [4][8];
  int slen [4], spos [4], hold [4], hold_once [4];
  int hold_max = 0, tx_cnt = 0, tx_fixed = 10, sc_at = -1, done_count = 0, to_seen = 0;
  bit rnd_mode = 0;
  logic [7:0] sent [$];
  int gorder [$];
  logic [3:0] prev_grant = 4'd0, last_owner = 4'd0;

  function automatic int oh_idx(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic bit srcs_idle();
    for (int s = 0; s < 4; s++) if (spos[s] < slen[s]) return 0;
    return 1;
  endfunction

  task automatic load(input int s, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) sbuf[s][i] = base + 8'(i);
    slen[s] = n; spos[s] = 0; hold[s] = 0;
  endtask

  task automatic abort_all();
    for (int s = 0; s < 4; s++) begin slen[s] = spos[s]; hold[s] = 0; end
  endtask

  task automatic cyc();
    @(negedge clk);
    soft_clr = 1'b0;
    tx_done  = 1'b0;
    if (o_grant != 4'd0 && prev_grant == 4'd0) gorder.push_back(oh_idx(o_grant));
    if (o_tx_start) sent.push_back(o_tx_data);
    if (o_timeout) begin
      to_seen++;
      for (int s = 0; s < 4; s++) if (last_owner[s]) slen[s] = spos[s];
    end
    if (o_grant != 4'd0) last_owner = o_grant;
    prev_grant = o_grant;
    for (int s = 0; s < 4; s++) begin
      if (o_ack[s]) begin
        spos[s]++;
        hold[s] = (hold_once[s] > 0) ? hold_once[s] :
                  (hold_max > 0) ? int'($urandom_range(hold_max, 0)) : 0;
        hold_once[s] = 0;
      end else if (hold[s] > 0) hold[s]--;
    end
    if (o_tx_start) tx_cnt = (tx_fixed > 0) ? tx_fixed : int'($urandom_range(8, 1));
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1; done_count++;
        if (sc_at == done_count) begin soft_clr = 1'b1; sc_at = -1; abort_all(); end
      end
    end else if (rnd_mode && $urandom_range(49, 0) == 0) tx_done = 1'b1;
    if (rnd_mode && $urandom_range(199, 0) == 0) soft_clr = 1'b1;
    for (int s = 0; s < 4; s++) begin
      req[s] = (spos[s] < slen[s]) && (hold[s] == 0);
      dat[s] = sbuf[s][spos[s] % 8];
      lst[s] = (spos[s] == slen[s] - 1);
    end
  endtask

  task automatic run_idle(input string nm, input int maxc);
    int c = 0;
    do begin cyc(); c++; end
    while ((!srcs_idle() || o_busy || tx_cnt > 0) && c < maxc);
    chk({nm, " drained"}, 32'(c < maxc), 32'd1);
  endtask

  function automatic int gat(input int i);
    return (gorder.size() > i) ? gorder[i] : -1;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int s = 0; s < 4; s++) begin
      slen[s] = 0; spos[s] = 0; hold[s] = 0; hold_once[s] = 0; dat[s] = 8'h00;
      for (int i = 0; i < 8; i++) sbuf[s][i] = 8'h00;
    end
    repeat (3) cyc();
    chk("reset outputs", {13'd0, o_grant, o_busy, o_tx_start, o_ack, o_timeout, o_tx_data}, 32'd0);
    rst = 1'b1;
    cyc();

    // Round robin from reset: 0 and 3 request, 0 re-requests
    gorder.delete();
    load(0, 1, 8'hA0); load(3, 1, 8'hB0);
    begin
      int reld = 1;
      for (int c = 0; c < 300; c++) begin
        cyc();
        if (spos[0] >= slen[0] && reld > 0) begin load(0, 1, 8'hA1); reld--; end
        if (reld == 0 && srcs_idle() && !o_busy && tx_cnt == 0) break;
      end
    end
    chk("rr order0", gat(0), 0);
    chk("rr order1", gat(1), 3);
    chk("rr order2", gat(2), 0);

    // Single 3-byte message from source 1
    sent.delete(); gorder.delete();
    load(1, 3, 8'h31);
    cyc();
    cyc(); chk("t1 grant c1", o_grant, 4'b0010);
    cyc(); chk("t1 start c2", {o_tx_start, o_ack, o_tx_data}, {1'b1, 4'b0010, 8'h31});
    run_idle("t1", 200);
    chk("t1 nbytes", sent.size(), 3);
    chk("t1 byte1", (sent.size() > 1) ? sent[1] : 8'h00, 8'h32);
    chk("t1 byte2", (sent.size() > 2) ? sent[2] : 8'h00, 8'h33);
    chk("t1 grant end", o_grant, 4'd0);
    gorder.delete();
    load(0, 1, 8'h40); load(3, 1, 8'h41);
    run_idle("rr after t1", 200);
    chk("rr ptr=2 winner", gat(0), 3);
    chk("rr ptr=2 second", gat(1), 0);

    // Stall timeout: source 2 stalls after byte 1, source 3 pending
    gorder.delete(); to_seen = 0; hold_once[2] = 40;
    load(2, 3, 8'h50); cyc(); cyc(); load(3, 1, 8'h60);
    run_idle("stall", 500);
    chk("stall timeouts", to_seen, TO_EN ? 1 : 0);
    chk("stall first", gat(0), 2);
    chk("stall next", gat(1), 3);

    // Long stall of source 0
    to_seen = 0; hold_once[0] = 300;
    load(0, 2, 8'h70);
    run_idle("long stall", 1000);
    chk("long stall timeouts", to_seen, TO_EN ? 1 : 0);

    // Soft clear coincident with tx_done mid-message
    gorder.delete(); n0 = sent.size(); sc_at = done_count + 2;
    load(1, 3, 8'h78);
    for (int c = 0; c < 200 && !soft_clr; c++) cyc();
    cyc();
    chk("sc idle", {o_busy, o_grant}, 5'd0);
    repeat (10) cyc();
    chk("sc starts", sent.size() - n0, 2);
    gorder.delete();
    load(1, 1, 8'h80); load(2, 1, 8'h90);
    run_idle("sc after", 200);
    chk("sc rr kept", gat(0), 1);

    // Async reset between bytes
    n0 = sent.size(); tx_fixed = 6;
    load(3, 3, 8'hC0);
    for (int c = 0; c < 50 && sent.size() == n0; c++) cyc();
    cyc(); cyc();
    rst = 1'b0; abort_all(); tx_cnt = 0; tx_done = 1'b0;
    #1 chk("arst immediate", {13'd0, o_grant, o_busy, o_tx_start, o_ack, o_timeout, o_tx_data}, 32'd0);
    cyc(); cyc();
    chk("arst held", {13'd0, o_grant, o_busy, o_tx_start, o_ack, o_timeout, o_tx_data}, 32'd0);
    rst = 1'b1;
    gorder.delete();
    load(1, 1, 8'hD0); load(3, 1, 8'hD1);
    run_idle("arst after", 200);
    chk("arst rr from 0", gat(0), 1);

    // Randomized traffic
    rnd_mode = 1; tx_fixed = 0; hold_max = 4;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 4; s++)
        if (spos[s] >= slen[s] && $urandom_range(19, 0) == 0)
          load(s, int'($urandom_range(4, 1)), 8'($urandom_range(255, 0)));
      cyc();
    end
    rnd_mode = 0; hold_max = 0;
    run_idle("random drain", 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
